// File: rtl/pll_mode_pkg.sv
// pll_mode_pkg: rPLL mode table, select encodings and sequencer state type
package pll_mode_pkg;

    localparam int MODE_W = 2;

    // Per-mode divider settings, index 3 first: 27, 40.5, 33.75, 9 MHz
    localparam logic [3:0][5:0] IDIV_SEL  = {6'd0, 6'd1, 6'd3, 6'd2};
    localparam logic [3:0][5:0] FBDIV_SEL = {6'd0, 6'd2, 6'd4, 6'd0};
    localparam logic [3:0][7:0] ODIV      = {8'd32, 8'd16, 8'd16, 8'd64};

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, SETTLE, READY, FAIL} state_t;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } sel_t;

    // Gowin ODSEL code: 64 - ODIV/2 (ODIV 2 -> 63, 16 -> 56, 128 -> 0)
    function automatic logic [5:0] odsel_code(input logic [7:0] odiv);
        return 6'(8'd64 - (odiv >> 1));
    endfunction

    // rPLL dynamic select values for one mode (IDSEL/FBDSEL are inverted)
    function automatic sel_t mode_sel(input logic [MODE_W-1:0] m);
        return '{idsel: 6'd63 - IDIV_SEL[m], fbdsel: 6'd63 - FBDIV_SEL[m], odsel: odsel_code(ODIV[m])};
    endfunction

endpackage

// File: rtl/pll_mode_seq_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Shift the asynchronous input through two flops
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_mode_seq.sv
// pll_mode_seq: rPLL reset/lock sequencer with run-time mode switching
module pll_mode_seq
    import pll_mode_pkg::*;
#(
    parameter int                RST_CYCLES    = 27,
    parameter int                LOCK_TIMEOUT  = 27000,
    parameter int                SETTLE_CYCLES = 2700,
    parameter int                MAX_RETRY     = 2,
    parameter logic [MODE_W-1:0] DEFAULT_MODE  = 2'd2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pll_lock,
    input  logic              req,
    input  logic [MODE_W-1:0] req_mode,
    output logic              pll_reset,
    output logic [5:0]        pll_idsel,
    output logic [5:0]        pll_fbdsel,
    output logic [5:0]        pll_odsel,
    output logic              clk_ready,
    output logic              lcd_rst_n,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              err,
    output logic [MODE_W-1:0] cur_mode
);
    localparam int MAX_A = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_P = LOCK_TIMEOUT > MAX_A ? LOCK_TIMEOUT : MAX_A;
    localparam int CNT_W = $clog2(MAX_P) + 1;
    localparam int RET_W = $clog2(MAX_RETRY + 1) + 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [RET_W-1:0]  retries, retries_nxt;
    logic [MODE_W-1:0] mode_nxt;
    logic              err_nxt, accept, lock_s;
    sel_t              sel;

    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign pll_reset  = state == RESET_PLL || state == FAIL;
    assign clk_ready  = state == READY;
    assign lcd_rst_n  = state == READY;
    assign fail       = state == FAIL;
    assign busy       = state == RESET_PLL || state == WAIT_LOCK || state == SETTLE;
    assign pll_idsel  = sel.idsel;
    assign pll_fbdsel = sel.fbdsel;
    assign pll_odsel  = sel.odsel;
    assign cnt_inc    = &cnt ? cnt : cnt + 1'b1;

    // Requests are taken only when idle; a same-mode request in READY is rejected
    assign accept  = req && (state == FAIL || (state == READY && req_mode != cur_mode));
    assign err_nxt = req && state == READY && req_mode == cur_mode;

    // Next-state logic: reset pulse, lock wait with retries, settle, idle
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_inc;
        retries_nxt = retries;
        mode_nxt    = cur_mode;
        case (state)
            RESET_PLL:
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            WAIT_LOCK:
                if (lock_s) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_nxt     = '0;
                    state_nxt   = retries < RET_W'(MAX_RETRY) ? RESET_PLL : FAIL;
                    retries_nxt = retries < RET_W'(MAX_RETRY) ? retries + 1'b1 : retries;
                end
            SETTLE:
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end
            READY, FAIL: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt   = RESET_PLL;
                    mode_nxt    = req_mode;
                    retries_nxt = '0;
                end else if (state == READY && !lock_s) begin
                    state_nxt   = WAIT_LOCK;
                    retries_nxt = '0;
                end
            end
            default: state_nxt = RESET_PLL;
        endcase
    end

    // State, counters, mode and registered select/pulse outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state    <= RESET_PLL;
            cnt      <= '0;
            retries  <= '0;
            cur_mode <= DEFAULT_MODE;
            sel      <= mode_sel(DEFAULT_MODE);
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            retries  <= retries_nxt;
            cur_mode <= mode_nxt;
            sel      <= mode_sel(mode_nxt);
            done     <= state_nxt == READY && state != READY;
            err      <= err_nxt;
        end
endmodule

// File: tb/tb_pll_mode_seq.sv
// tb_pll_mode_seq: scoreboard bench for the rPLL mode sequencer
module tb_pll_mode_seq;
    localparam int K_DONE = 0, K_ERR = 1, K_FAILR = 2, K_RSTF = 3;

    logic       sys_clk = 1'b0, sys_rst_n = 1'b1, req = 1'b0, lock_en = 1'b1, lock_m = 1'b0;
    logic [1:0] req_mode = 2'd0;
    logic       pll_lock, pll_reset, clk_ready, lcd_rst_n, busy, done, fail, err;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [1:0] cur_mode;
    int         cyc = 0, lk_cnt = 0, vectors = 0, miscompares = 0;

    typedef struct {
        int         kind;
        int         at;
        logic [1:0] mode;
        int         id, fb, od;
        logic       rdy, bsy;
    } ev_t;
    ev_t   exp_q[$];
    string kname[4] = '{"done", "err", "fail_rise", "rst_fall"};
    // Hand-computed select values per mode: idsel, fbdsel, odsel
    int    id_tab[4] = '{61, 60, 62, 63};
    int    fb_tab[4] = '{63, 59, 61, 63};
    int    od_tab[4] = '{32, 56, 56, 48};

    pll_mode_seq #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (50),
        .SETTLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pll_lock   (pll_lock),
        .req        (req),
        .req_mode   (req_mode),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .clk_ready  (clk_ready),
        .lcd_rst_n  (lcd_rst_n),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .err        (err),
        .cur_mode   (cur_mode)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // PLL model: lock rises 10 cycles after RESET is released
    always @(posedge sys_clk)
        if (pll_reset) begin
            lk_cnt <= 0;
            lock_m <= 1'b0;
        end else if (lk_cnt == 9) lock_m <= 1'b1;
        else lk_cnt <= lk_cnt + 1;
    assign pll_lock = lock_m & lock_en;

    task automatic check(string name, int got, int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(int kind, int at, int m);
        ev_t e;
        e.kind = kind; e.at = at; e.mode = 2'(m);
        e.id = id_tab[m]; e.fb = fb_tab[m]; e.od = od_tab[m];
        e.rdy = kind == K_DONE || kind == K_ERR;
        e.bsy = kind == K_RSTF;
        exp_q.push_back(e);
    endtask

    task automatic observe(int kind);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s at cycle %0d", kname[kind], cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.at != cyc || e.mode != cur_mode || e.id != int'(pll_idsel) ||
            e.fb != int'(pll_fbdsel) || e.od != int'(pll_odsel) || e.rdy != clk_ready || e.bsy != busy) begin
            miscompares++;
            $display("FAIL event: got %s cyc=%0d mode=%0d id=%0d fb=%0d od=%0d rdy=%b busy=%b, expected %s cyc=%0d mode=%0d id=%0d fb=%0d od=%0d rdy=%b busy=%b",
                     kname[kind], cyc, cur_mode, pll_idsel, pll_fbdsel, pll_odsel, clk_ready, busy,
                     kname[e.kind], e.at, e.mode, e.id, e.fb, e.od, e.rdy, e.bsy);
        end
    endtask

    // Monitor: every pulse, fail rise and pll_reset fall is popped and compared
    logic prev_rst = 1'b1, prev_fail = 1'b0;
    always @(negedge sys_clk) begin
        if (done) observe(K_DONE);
        if (err) observe(K_ERR);
        if (fail && !prev_fail) observe(K_FAILR);
        if (!pll_reset && prev_rst) observe(K_RSTF);
        prev_rst  <= pll_reset;
        prev_fail <= fail;
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d events still pending after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic check_reset_vals();
        check("rst pll_reset", pll_reset, 1);
        check("rst busy", busy, 1);
        check("rst clk_ready", clk_ready, 0);
        check("rst lcd_rst_n", lcd_rst_n, 0);
        check("rst done", done, 0);
        check("rst fail", fail, 0);
        check("rst err", err, 0);
        check("rst cur_mode", cur_mode, 2);
        check("rst idsel", pll_idsel, 62);
        check("rst fbdsel", pll_fbdsel, 61);
        check("rst odsel", pll_odsel, 56);
    endtask

    initial begin
        int t;
        #1 sys_rst_n = 1'b0;
        repeat (3) step();
        check_reset_vals();

        // Power-up auto-start with the default mode
        sys_rst_n = 1'b1;
        t = cyc;
        push(K_RSTF, t + 4, 2);
        push(K_DONE, t + 25, 2);
        drain("power-up", 60);
        check("pwrup clk_ready", clk_ready, 1);
        check("pwrup lcd_rst_n", lcd_rst_n, 1);

        // Mode switch to 0, with a request while busy that must be ignored
        step(); t = cyc; req = 1'b1; req_mode = 2'd0;
        push(K_RSTF, t + 5, 0);
        push(K_DONE, t + 26, 0);
        step(); req = 1'b0;
        @(negedge sys_clk);
        check("switch busy", busy, 1);
        check("switch clk_ready", clk_ready, 0);
        check("switch pll_reset", pll_reset, 1);
        check("switch idsel", pll_idsel, 61);
        check("switch fbdsel", pll_fbdsel, 63);
        check("switch cur_mode", cur_mode, 0);
        repeat (6) step();
        req = 1'b1; req_mode = 2'd3;
        step(); req = 1'b0;
        @(negedge sys_clk);
        check("busy req cur_mode", cur_mode, 0);
        check("busy req idsel", pll_idsel, 61);
        drain("mode switch", 60);

        // Switch to mode 1 with a one-cycle lock glitch during settle
        step(); t = cyc; req = 1'b1; req_mode = 2'd1;
        push(K_RSTF, t + 5, 1);
        push(K_DONE, t + 32, 1);
        step(); req = 1'b0;
        repeat (19) step();
        lock_en = 1'b0;
        step(); lock_en = 1'b1;
        drain("settle glitch", 60);

        // Lock loss in READY: no PLL reset, back to READY
        step(); t = cyc; lock_en = 1'b0;
        push(K_DONE, t + 14, 1);
        step(); step();
        @(negedge sys_clk);
        check("pre-drop clk_ready", clk_ready, 1);
        step(); lock_en = 1'b1;
        @(negedge sys_clk);
        check("drop clk_ready", clk_ready, 0);
        check("drop lcd_rst_n", lcd_rst_n, 0);
        check("drop pll_reset", pll_reset, 0);
        drain("lock drop", 40);

        // Same-mode request in READY is rejected with an err pulse
        step(); t = cyc; req = 1'b1; req_mode = 2'd1;
        push(K_ERR, t + 1, 1);
        step(); req = 1'b0;
        step();
        @(negedge sys_clk);
        check("err clk_ready", clk_ready, 1);
        check("err busy", busy, 0);
        check("err cur_mode", cur_mode, 1);
        drain("same-mode err", 10);

        // Lock never comes: three reset pulses then FAIL
        step(); t = cyc; lock_en = 1'b0; req = 1'b1; req_mode = 2'd3;
        push(K_RSTF, t + 5, 3);
        push(K_RSTF, t + 59, 3);
        push(K_RSTF, t + 113, 3);
        push(K_FAILR, t + 163, 3);
        step(); req = 1'b0;
        drain("lock timeout", 250);
        check("fail level", fail, 1);
        check("fail busy", busy, 0);
        check("fail pll_reset", pll_reset, 1);

        // A new request clears FAIL
        step(); t = cyc; lock_en = 1'b1; req = 1'b1; req_mode = 2'd3;
        push(K_RSTF, t + 5, 3);
        push(K_DONE, t + 26, 3);
        step(); req = 1'b0;
        @(negedge sys_clk);
        check("retry fail", fail, 0);
        check("retry busy", busy, 1);
        drain("retry after fail", 60);

        // Asynchronous reset while waiting for lock
        step(); t = cyc; req = 1'b1; req_mode = 2'd0;
        push(K_RSTF, t + 5, 0);
        step(); req = 1'b0;
        repeat (8) step();
        sys_rst_n = 1'b0;
        #1;
        check_reset_vals();
        step(); step();
        sys_rst_n = 1'b1;
        t = cyc;
        push(K_RSTF, t + 4, 2);
        push(K_DONE, t + 25, 2);
        drain("restart after reset", 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pll_mode_seq.md
# pll_mode_seq

Sequencer for the rPLL pixel-clock generator of the RGB LCD designs. Runs on the 27 MHz crystal clock, drives the rPLL dynamic divider selects (IDSEL/FBDSEL/ODSEL) and RESET from a small mode table, and waits for a stable LOCK. It gates the LCD timing logic via `clk_ready`/`lcd_rst_n`, so one bitstream can switch between panel pixel clocks at run time.

## Interface
- `RST_CYCLES`, 27: cycles `pll_reset` is held high per attempt (1 µs).
- `LOCK_TIMEOUT`, 27000: cycles allowed for lock per attempt (1 ms).
- `SETTLE_CYCLES`, 2700: cycles lock must stay continuously high before ready (100 µs).
- `MAX_RETRY`, 2: extra attempts after the first timeout before FAIL.
- `DEFAULT_MODE`, 2: mode started automatically after reset.

Ports:
- `sys_clk` in 1: 27 MHz crystal clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `pll_lock` in 1: rPLL LOCK, asynchronous to `sys_clk`.
- `req` in 1: mode-change request, sampled when not busy.
- `req_mode` in 2: requested mode index.
- `pll_reset` out 1: to rPLL RESET.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel` out 6 each: to rPLL dynamic selects.
- `clk_ready` out 1: pixel clock valid.
- `lcd_rst_n` out 1: active-low reset for the LCD timing domain. Downstream re-synchronises it.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on reaching READY.
- `fail` out 1: level, high in FAIL.
- `err` out 1: one-cycle pulse on a rejected request.
- `cur_mode` out 2: mode currently programmed.

## Operation
- Mode table (IDIV_SEL, FBDIV_SEL, ODIV):
  - 0 = 9 MHz: 2, 0, 64.
  - 1 = 33.75 MHz: 3, 4, 16.
  - 2 = 40.5 MHz: 1, 2, 16.
  - 3 = 27 MHz: 0, 0, 32.
- Encoding: `pll_idsel` = 63 − IDIV_SEL; `pll_fbdsel` = 63 − FBDIV_SEL; `pll_odsel` = Gowin ODSEL code for ODIV (package constants). All three are registered.
- `pll_lock` passes through a 2-flop synchroniser to give `lock_s`. Only `lock_s` is used.
- States:
  - RESET_PLL: `pll_reset`=1, selects updated. After RST_CYCLES, go to WAIT_LOCK.
  - WAIT_LOCK: `lock_s`=1 → SETTLE. Timeout counter reaching LOCK_TIMEOUT: if retries < MAX_RETRY, retries+1 and go to RESET_PLL; else go to FAIL.
  - SETTLE: `lock_s`=0 → WAIT_LOCK, with the timeout counter cleared. SETTLE_CYCLES consecutive high cycles → READY.
  - READY: `clk_ready`=1, `lcd_rst_n`=1, `busy`=0.
  - FAIL: `fail`=1, `busy`=0, `pll_reset`=1.
- Request acceptance (READY or FAIL only):
  - `req`=1 with `req_mode` ≤ 3 latches the mode, clears retries, clears `fail`, enters RESET_PLL.
  - Table is full-range for 2 bits, so `err` fires only when `req`=1 in READY with `req_mode` == `cur_mode`. No action is taken in that case.
- `req` while `busy`=1 is ignored. No queuing, no `err`.
- Lock loss in READY: `lock_s`=0 → WAIT_LOCK without PLL reset. `clk_ready` and `lcd_rst_n` drop in the same cycle. Retries are cleared.
- `clk_ready`=0 and `lcd_rst_n`=0 in every state except READY.

## Timing
- Reset values:
  - state RESET_PLL, `pll_reset`=1, `busy`=1.
  - `clk_ready`=0, `lcd_rst_n`=0, `done`=0, `fail`=0, `err`=0.
  - `cur_mode`=DEFAULT_MODE; selects hold DEFAULT_MODE encodings.
  - All counters 0.
- `sys_rst_n` asserted mid-sequence aborts immediately to the reset values. The auto-start then reruns with DEFAULT_MODE.
- Accepting a request is registered:
  - cycle N: `req` seen.
  - cycle N+1: state RESET_PLL, `busy`=1, `pll_reset`=1, new selects and `cur_mode`.
- Selects are stable ≥ RST_CYCLES before `pll_reset` falls, and are never changed while `pll_reset`=0.
- `pll_lock` rise to `lock_s` rise: 2 cycles.
- Shortest path from `pll_reset` fall to READY, with lock present immediately: 2 + 1 + SETTLE_CYCLES cycles.
- `done` is high in the first READY cycle only.
- Counters are sized $clog2 of the largest parameter plus 1. They saturate and never wrap.

## Structure
- Package `pll_mode_pkg`:
  - mode table (IDIV/FBDIV/ODIV per mode).
  - ODIV→ODSEL code function.
  - state enum.
  - `MODE_W`=2.
- Sub-module `sync_2ff` for `lock_s`. Counters and FSM live in the top.

## Test plan
Parameters for all tests: RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=8, MAX_RETRY=2. The PLL model raises lock 10 cycles after reset release.
1. Power-up: release `sys_rst_n` → `pll_idsel`=62, `pll_fbdsel`=61; `pll_reset` high exactly 4 cycles; `done` pulse and `clk_ready`=1 at 4+10+2+1+8 cycles.
2. Mode switch: `req`=1, `req_mode`=0 in READY → next cycle `busy`=1, `clk_ready`=0, `pll_idsel`=61, `pll_fbdsel`=63; READY again with `cur_mode`=0.
3. Lock never rises → exactly 3 `pll_reset` pulses, then `fail`=1, `busy`=0. A new `req` clears `fail`.
4. Lock glitch low for 1 cycle during SETTLE → settle restarts; READY 8 cycles after the glitch clears (plus sync latency).
5. Lock drop in READY → `clk_ready`/`lcd_rst_n` fall the cycle after the `lock_s` drop, no `pll_reset`; returns to READY.
6. Edge cases:
   - `req` while busy → ignored.
   - `req` with same mode in READY → `err` pulse, state unchanged.
   - `sys_rst_n` low during WAIT_LOCK → all outputs at reset values asynchronously.
